trigger_conditioner: RTL and testbench

Per-channel front end for the raw trigger inputs, sitting directly upstream of the four counter modules. Each channel synchronizes its asynchronous trigger pin, rejects glitches shorter than a programmable width, and emits exactly one single-cycle qualified pulse per accepted trigger. After each accepted trigger it enforces a lockout window and counts bounces rejected inside that window. The counters consume only clean, single-clock pulses.

---
 rtl/trigger_conditioner_if.sv | 29 ++
 rtl/trigger_conditioner.sv | 159 +++++++++++++++
 tb/tb_trigger_conditioner.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module  : trigger_conditioner_if
// Brief   : Trigger inputs, control strobes and conditioned outputs bundle.
// Rev     : 1.0
// ============================================================================
interface trigger_conditioner_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       trigg_in;
    logic                  enable;
    logic                  clear_stats;
    logic [N_CH-1:0]       trigg_pulse;
    logic [N_CH-1:0]       trigg_level;
    logic [N_CH-1:0]       busy;
    logic [N_CH*CNT_W-1:0] reject_cnt;

    modport master (
        output trigg_in, enable, clear_stats,
        input  trigg_pulse, trigg_level, busy, reject_cnt
    );

    modport slave (
        input  trigg_in, enable, clear_stats,
        output trigg_pulse, trigg_level, busy, reject_cnt
    );
endinterface
`default_nettype wire

// File: rtl/trigger_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : trigger_conditioner
// Brief   : Per-channel synchronizer, glitch filter, one-shot pulse, lockout
//           window and saturating bounce counter for raw trigger pins.
// Rev     : 1.0
// ============================================================================
module trigger_conditioner #(
    parameter int N_CH           = 4,
    parameter int FILTER_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    trigger_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_LOCKOUT  = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    localparam int QW = (FILTER_CYCLES  > 1) ? $clog2(FILTER_CYCLES)  : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [QW-1:0]    C_Q_LAST  = QW'(FILTER_CYCLES - 1);
    localparam logic [LW-1:0]    C_L_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [N_CH-1:0]       w_pulse;
    logic [N_CH-1:0]       w_level;
    logic [N_CH-1:0]       w_busy;
    logic [N_CH*CNT_W-1:0] w_cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             r_meta;
        logic             r_s;
        logic             r_s_d;
        state_t           r_state;
        logic [QW-1:0]    r_qcnt;
        logic [LW-1:0]    r_lcnt;
        logic             r_pulse;
        logic             r_level;
        logic             r_busy;
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;

        // Bounces are only counted while the lockout window is live.
        assign w_inc = bus.enable && (r_state == ST_LOCKOUT) && r_s && !r_s_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta  <= 1'b0;
                r_s     <= 1'b0;
                r_s_d   <= 1'b0;
                r_state <= ST_IDLE;
                r_qcnt  <= '0;
                r_lcnt  <= '0;
                r_pulse <= 1'b0;
                r_level <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_meta  <= bus.trigg_in[i];
                r_s     <= r_meta;
                r_s_d   <= r_s;
                r_pulse <= 1'b0;
                if (!bus.enable) begin
                    r_state <= ST_IDLE;
                    r_qcnt  <= '0;
                    r_lcnt  <= '0;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (r_s) begin
                                if (FILTER_CYCLES == 1) begin
                                    r_state <= ST_LOCKOUT;
                                    r_pulse <= 1'b1;
                                    r_level <= 1'b1;
                                    r_busy  <= 1'b1;
                                    r_lcnt  <= '0;
                                end else begin
                                    r_state <= ST_QUALIFY;
                                    r_qcnt  <= QW'(1);
                                end
                            end
                        end
                        ST_QUALIFY: begin
                            if (!r_s) begin
                                r_state <= ST_IDLE;
                                r_qcnt  <= '0;
                            end else if (r_qcnt == C_Q_LAST) begin
                                r_state <= ST_LOCKOUT;
                                r_qcnt  <= '0;
                                r_pulse <= 1'b1;
                                r_level <= 1'b1;
                                r_busy  <= 1'b1;
                                r_lcnt  <= '0;
                            end else begin
                                r_qcnt <= r_qcnt + 1'b1;
                            end
                        end
                        ST_LOCKOUT: begin
                            if (r_lcnt == C_L_LAST) begin
                                r_lcnt <= '0;
                                r_busy <= 1'b0;
                                if (r_s) begin
                                    r_state <= ST_WAIT_LOW;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_level <= 1'b0;
                                end
                            end else begin
                                r_lcnt <= r_lcnt + 1'b1;
                            end
                        end
                        ST_WAIT_LOW: begin
                            if (!r_s) begin
                                r_state <= ST_IDLE;
                                r_level <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_level <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        // Clear has priority over a same-cycle increment.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (bus.clear_stats) begin
                r_cnt <= '0;
            end else if (w_inc && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_pulse[i]               = r_pulse;
        assign w_level[i]               = r_level;
        assign w_busy[i]                = r_busy;
        assign w_cnt[i*CNT_W +: CNT_W]  = r_cnt;
    end

    assign bus.trigg_pulse = w_pulse;
    assign bus.trigg_level = w_level;
    assign bus.busy        = w_busy;
    assign bus.reject_cnt  = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trigger_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_trigger_conditioner
// Brief   : Directed self-checking bench for trigger_conditioner.
// Rev     : 1.0
// ============================================================================
module tb_trigger_conditioner;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    trigger_conditioner_if #(.N_CH(4), .CNT_W(16)) bus_m ();
    trigger_conditioner_if #(.N_CH(4), .CNT_W(2))  bus_s ();

    trigger_conditioner #(
        .N_CH(4), .FILTER_CYCLES(8), .LOCKOUT_CYCLES(1000), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_m)
    );

    trigger_conditioner #(
        .N_CH(4), .FILTER_CYCLES(8), .LOCKOUT_CYCLES(200), .CNT_W(2)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_m.trigg_in = 4'h0; bus_m.enable = 1'b1; bus_m.clear_stats = 1'b0;
        bus_s.trigg_in = 4'h0; bus_s.enable = 1'b1; bus_s.clear_stats = 1'b0;
        tick(); tick();
        n_checks++;
        if (bus_m.trigg_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_pulse: got %h expected 0", bus_m.trigg_pulse); end
        n_checks++;
        if (bus_m.trigg_level !== 4'h0) begin n_fail++; $display("FAIL reset_level: got %h expected 0", bus_m.trigg_level); end
        n_checks++;
        if (bus_m.busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", bus_m.busy); end
        n_checks++;
        if (bus_m.reject_cnt !== 64'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", bus_m.reject_cnt); end
        n_checks++;
        if (bus_s.reject_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_cnt_s: got %h expected 0", bus_s.reject_cnt); end
        reset_n = 1'b1;
        tick(); tick();
        n_checks++;
        if ((bus_m.busy | bus_m.trigg_pulse) !== 4'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", bus_m.busy | bus_m.trigg_pulse); end
    endtask

    task automatic test_clean_trigger();
        int   first_pulse = -1;
        int   pulses = 0, busy_n = 0, level_n = 0;
        logic others = 1'b0, rise_together = 1'b0;
        bus_m.trigg_in[0] = 1'b1;
        for (int e = 0; e < 1100; e++) begin
            tick();
            if (bus_m.trigg_pulse[0]) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse   = e;
                    rise_together = bus_m.busy[0] & bus_m.trigg_level[0];
                end
            end
            if (bus_m.busy[0]) busy_n++;
            if (bus_m.trigg_level[0]) level_n++;
            if ((|bus_m.trigg_pulse[3:1]) || (|bus_m.busy[3:1])) others = 1'b1;
            if (e == 49) bus_m.trigg_in[0] = 1'b0;
        end
        n_checks++;
        if (first_pulse !== 9) begin n_fail++; $display("FAIL clean_latency: got edge %0d expected 9", first_pulse); end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL clean_pulse_count: got %0d expected 1", pulses); end
        n_checks++;
        if (busy_n !== 1000) begin n_fail++; $display("FAIL clean_busy_len: got %0d expected 1000", busy_n); end
        n_checks++;
        if (level_n !== 1000) begin n_fail++; $display("FAIL clean_level_len: got %0d expected 1000", level_n); end
        n_checks++;
        if (rise_together !== 1'b1) begin n_fail++; $display("FAIL clean_busy_level_with_pulse: got %b expected 1", rise_together); end
        n_checks++;
        if (others !== 1'b0) begin n_fail++; $display("FAIL clean_other_channels: got %b expected 0", others); end
    endtask

    task automatic test_glitch();
        int pulses = 0, busy_n = 0, first_pulse = -1;
        bus_m.trigg_in[1] = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (bus_m.trigg_pulse[1]) pulses++;
            if (bus_m.busy[1]) busy_n++;
            if (e == 6) bus_m.trigg_in[1] = 1'b0;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL glitch7_pulse: got %0d expected 0", pulses); end
        n_checks++;
        if (busy_n !== 0) begin n_fail++; $display("FAIL glitch7_busy: got %0d expected 0", busy_n); end
        n_checks++;
        if (bus_m.reject_cnt[16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL glitch7_cnt: got %0d expected 0", bus_m.reject_cnt[16 +: 16]); end
        pulses = 0;
        bus_m.trigg_in[1] = 1'b1;
        for (int e = 0; e < 1100; e++) begin
            tick();
            if (bus_m.trigg_pulse[1]) begin
                pulses++;
                if (first_pulse < 0) first_pulse = e;
            end
            if (e == 7) bus_m.trigg_in[1] = 1'b0;
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL filter8_pulse: got %0d expected 1", pulses); end
        n_checks++;
        if (first_pulse !== 9) begin n_fail++; $display("FAIL filter8_latency: got %0d expected 9", first_pulse); end
    endtask

    task automatic test_bounce();
        int   pulses = 0;
        int   n;
        logic lvl;
        bus_m.trigg_in[2] = 1'b1;
        for (int e = 0; e < 1120; e++) begin
            tick();
            if (bus_m.trigg_pulse[2]) pulses++;
            if (e == 25) begin
                n_checks++;
                if (bus_m.reject_cnt[32 +: 16] !== 16'd0) begin n_fail++; $display("FAIL bounce_cnt_e25: got %0d expected 0", bus_m.reject_cnt[32 +: 16]); end
            end
            if (e == 26) begin
                n_checks++;
                if (bus_m.reject_cnt[32 +: 16] !== 16'd1) begin n_fail++; $display("FAIL bounce_cnt_e26: got %0d expected 1", bus_m.reject_cnt[32 +: 16]); end
            end
            if (e == 49) begin
                n_checks++;
                if (bus_m.reject_cnt[32 +: 16] !== 16'd3) begin n_fail++; $display("FAIL bounce_cnt3: got %0d expected 3", bus_m.reject_cnt[32 +: 16]); end
            end
            if (e == 50) begin
                n_checks++;
                if (bus_m.reject_cnt[32 +: 16] !== 16'd0) begin n_fail++; $display("FAIL bounce_clear_wins: got %0d expected 0", bus_m.reject_cnt[32 +: 16]); end
            end
            if (e == 1050) begin
                n_checks++;
                if ({bus_m.busy[2], bus_m.trigg_level[2]} !== 2'b01) begin n_fail++; $display("FAIL bounce_wait_low: got busy,level %b expected 01", {bus_m.busy[2], bus_m.trigg_level[2]}); end
            end
            if (e == 1115) begin
                n_checks++;
                if (bus_m.trigg_level[2] !== 1'b0) begin n_fail++; $display("FAIL bounce_level_release: got %b expected 0", bus_m.trigg_level[2]); end
            end
            n   = e + 1;
            lvl = (n < 20) || (n >= 48 && n < 1100) || (n >= 20 && n < 48 && ((n - 20) / 4) % 2 == 1);
            bus_m.trigg_in[2]  = lvl;
            bus_m.clear_stats  = (n == 50);
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_held_high();
        int   pulses = 0, p1 = -1, p2 = -1;
        int   n;
        bus_m.trigg_in[3] = 1'b1;
        for (int e = 0; e < 2040; e++) begin
            tick();
            if (bus_m.trigg_pulse[3]) begin
                pulses++;
                if (p1 < 0) p1 = e; else if (p2 < 0) p2 = e;
            end
            if (e == 1500) begin
                n_checks++;
                if ({bus_m.busy[3], bus_m.trigg_level[3]} !== 2'b01) begin n_fail++; $display("FAIL held_wait_low: got busy,level %b expected 01", {bus_m.busy[3], bus_m.trigg_level[3]}); end
            end
            if (e == 2001) begin
                n_checks++;
                if (bus_m.trigg_level[3] !== 1'b1) begin n_fail++; $display("FAIL held_level_e2001: got %b expected 1", bus_m.trigg_level[3]); end
            end
            if (e == 2002) begin
                n_checks++;
                if (bus_m.trigg_level[3] !== 1'b0) begin n_fail++; $display("FAIL held_level_e2002: got %b expected 0", bus_m.trigg_level[3]); end
            end
            n = e + 1;
            bus_m.trigg_in[3] = (n < 2000) || (n >= 2001 && n <= 2008);
        end
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL held_pulse_count: got %0d expected 2", pulses); end
        n_checks++;
        if (p1 !== 9) begin n_fail++; $display("FAIL held_first_pulse: got %0d expected 9", p1); end
        n_checks++;
        if (p2 !== 2010) begin n_fail++; $display("FAIL held_second_pulse: got %0d expected 2010", p2); end
    endtask

    task automatic test_saturation();
        int pulses = 0, busy_n = 0;
        int n;
        bus_s.trigg_in[0] = 1'b1;
        for (int e = 0; e < 240; e++) begin
            tick();
            if (bus_s.trigg_pulse[0]) pulses++;
            if (bus_s.busy[0]) busy_n++;
            if (e == 35) begin
                n_checks++;
                if (bus_s.reject_cnt[1:0] !== 2'd2) begin n_fail++; $display("FAIL sat_cnt2: got %0d expected 2", bus_s.reject_cnt[1:0]); end
            end
            if (e == 43) begin
                n_checks++;
                if (bus_s.reject_cnt[1:0] !== 2'd3) begin n_fail++; $display("FAIL sat_cnt3: got %0d expected 3", bus_s.reject_cnt[1:0]); end
            end
            if (e == 100) begin
                n_checks++;
                if (bus_s.reject_cnt[1:0] !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", bus_s.reject_cnt[1:0]); end
            end
            n = e + 1;
            bus_s.trigg_in[0] = (n < 20) || (n >= 20 && n < 60 && ((n - 20) / 4) % 2 == 1);
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL sat_pulse_count: got %0d expected 1", pulses); end
        n_checks++;
        if (busy_n !== 200) begin n_fail++; $display("FAIL sat_busy_len: got %0d expected 200", busy_n); end
    endtask

    task automatic test_simultaneous();
        bus_s.trigg_in = 4'hF;
        for (int e = 0; e < 240; e++) begin
            tick();
            if (e == 8 || e == 10) begin
                n_checks++;
                if (bus_s.trigg_pulse !== 4'h0) begin n_fail++; $display("FAIL sim_pulse_e%0d: got %h expected 0", e, bus_s.trigg_pulse); end
            end
            if (e == 9) begin
                n_checks++;
                if (bus_s.trigg_pulse !== 4'hF) begin n_fail++; $display("FAIL sim_pulse_all: got %h expected f", bus_s.trigg_pulse); end
            end
            if (e == 19) bus_s.trigg_in = 4'h0;
        end
        n_checks++;
        if (bus_s.reject_cnt !== 8'h03) begin n_fail++; $display("FAIL sim_cnt_independent: got %h expected 03", bus_s.reject_cnt); end
    endtask

    task automatic test_reset_enable();
        int n;
        int any = 0;
        bus_m.trigg_in[0] = 1'b1;
        for (int e = 0; e < 510; e++) begin
            tick();
            if (e == 100) begin
                n_checks++;
                if (bus_m.reject_cnt[15:0] !== 16'd1) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d expected 1", bus_m.reject_cnt[15:0]); end
            end
            n = e + 1;
            bus_m.trigg_in[0] = (n < 20) || (n >= 24 && n < 28);
        end
        n_checks++;
        if (bus_m.busy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", bus_m.busy[0]); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_m.busy !== 4'h0) begin n_fail++; $display("FAIL rst_async_busy: got %h expected 0", bus_m.busy); end
        n_checks++;
        if (bus_m.trigg_level !== 4'h0) begin n_fail++; $display("FAIL rst_async_level: got %h expected 0", bus_m.trigg_level); end
        n_checks++;
        if (bus_m.reject_cnt !== 64'h0) begin n_fail++; $display("FAIL rst_async_cnt: got %h expected 0", bus_m.reject_cnt); end
        n_checks++;
        if (bus_s.reject_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_async_cnt_s: got %h expected 0", bus_s.reject_cnt); end
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();
        bus_m.enable = 1'b0;
        bus_m.trigg_in[0] = 1'b1;
        for (int e = 0; e < 140; e++) begin
            tick();
            if ((|bus_m.trigg_pulse) || (|bus_m.busy) || (|bus_m.trigg_level)) any++;
            if (e == 99) bus_m.trigg_in[0] = 1'b0;
        end
        n_checks++;
        if (any !== 0) begin n_fail++; $display("FAIL enable_low_quiet: got %0d active cycles expected 0", any); end
        bus_m.enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_trigger();
        test_glitch();
        test_bounce();
        test_held_high();
        test_saturation();
        test_simultaneous();
        test_reset_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
